// File: rtl/accel_apb_cmdfifo.sv
// APB command FIFO slave: software pushes 32-bit words through a register, the
// accelerator core drains them over a valid/ready stream.
package accel_apb_cmdfifo_pkg;

  localparam int unsigned SYSBUS_ADDR_W = 48;
  localparam logic [15:0] VENDOR_OPTIMITECH      = 16'h00F1;
  localparam logic [7:0]  PNP_CFG_DEV_DESCR_BYTES = 8'h14;
  localparam logic [1:0]  PNP_CFG_TYPE_SLAVE      = 2'h2;

  typedef struct packed {
    logic [SYSBUS_ADDR_W-1:0] addr_start;
    logic [SYSBUS_ADDR_W-1:0] addr_end;
  } mapinfo_type;

  typedef struct packed {
    logic [7:0]               descrsize;
    logic [1:0]               descrtype;
    logic [SYSBUS_ADDR_W-1:0] addr_start;
    logic [SYSBUS_ADDR_W-1:0] addr_end;
    logic [15:0]              vid;
    logic [15:0]              did;
  } dev_config_type;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_in_type;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_out_type;

endpackage

module accel_apb_cmdfifo
  import accel_apb_cmdfifo_pkg::*;
#(
  parameter logic        async_reset = 1'b1,
  parameter logic [15:0] did         = 16'h0000,
  parameter int unsigned depth_log2  = 4
) (
  input  logic           i_clk,
  input  logic           i_nrst,
  input  mapinfo_type    i_mapinfo,
  output dev_config_type o_cfg,
  input  apb_in_type     i_apbi,
  output apb_out_type    o_apbo,
  output logic           o_cmd_valid,
  output logic [31:0]    o_cmd_data,
  input  logic           i_cmd_ready,
  output logic           o_irq
);

  localparam int unsigned DEPTH = 2 ** depth_log2;
  localparam int unsigned CNT_W = depth_log2 + 1;
  localparam logic [31:0] ID_VALUE = 32'hACCE_C0F0;
  localparam logic [depth_log2-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  typedef struct packed {
    state_t                     state;
    logic                       pready;
    logic [31:0]                prdata;
    logic                       pslverr;
    logic [depth_log2-1:0]      rd_ptr;
    logic [depth_log2-1:0]      wr_ptr;
    logic [CNT_W-1:0]           count;
    logic                       enable;
    logic                       irq_en;
    logic [7:0]                 thresh;
    logic                       overflow;
    logic                       strb_err;
    logic                       irq;
    logic [DEPTH-1:0][31:0]     mem;
  } regs_t;

  localparam regs_t R_RESET = '0;

  regs_t       r;
  regs_t       v;
  logic        acc;
  logic        push;
  logic        pop;
  logic        flush;
  logic        err;
  logic [31:0] rdata;
  logic [9:0]  off;
  logic        empty_c;
  logic        full_c;
  logic        cmd_valid_c;
  logic [31:0] status_c;
  logic        unused_apb;

  assign empty_c     = (r.count == '0);
  assign full_c      = (r.count == CNT_FULL);
  assign cmd_valid_c = r.enable & ~empty_c;
  assign status_c    = {16'h0000, 8'(r.count), 4'h0, r.strb_err, r.overflow, full_c, empty_c};
  assign off         = i_apbi.paddr[11:2];
  assign unused_apb  = ^{i_apbi.paddr[31:12], i_apbi.paddr[1:0], i_apbi.pprot};

  // APB FSM, register file side effects and FIFO bookkeeping
  always_comb begin
    v     = r;
    acc   = 1'b0;
    push  = 1'b0;
    flush = 1'b0;
    err   = 1'b0;
    rdata = '0;
    pop   = cmd_valid_c & i_cmd_ready;

    case (r.state)
      ST_IDLE: begin
        v.pready = 1'b0;
        if (i_apbi.pselx && i_apbi.penable) begin
          acc      = 1'b1;
          v.pready = 1'b1;
          v.state  = ST_RESP;
        end
      end
      ST_RESP: begin
        v.pready = 1'b0;
        v.state  = ST_IDLE;
      end
      default: v.state = ST_IDLE;
    endcase

    if (acc) begin
      case (off)
        10'h000: rdata = ID_VALUE;
        10'h001: begin
          rdata = status_c;
          if (i_apbi.pwrite) begin
            if (i_apbi.pwdata[2]) v.overflow = 1'b0;
            if (i_apbi.pwdata[3]) v.strb_err = 1'b0;
          end
        end
        10'h002: begin
          rdata = {29'h0, r.irq_en, 1'b0, r.enable};
          if (i_apbi.pwrite && i_apbi.pstrb[0]) begin
            v.enable = i_apbi.pwdata[0];
            flush    = i_apbi.pwdata[1];
            v.irq_en = i_apbi.pwdata[2];
          end
        end
        10'h003: begin
          if (i_apbi.pwrite) begin
            if (i_apbi.pstrb != 4'hF) begin
              err        = 1'b1;
              v.strb_err = 1'b1;
            end else if (full_c) begin
              // fullness is judged before any pop in this cycle
              err        = 1'b1;
              v.overflow = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
        end
        10'h004: begin
          rdata = {24'h0, r.thresh};
          if (i_apbi.pwrite && i_apbi.pstrb[0]) v.thresh = i_apbi.pwdata[7:0];
        end
        default: err = 1'b1;
      endcase
      v.prdata  = i_apbi.pwrite ? 32'h0 : rdata;
      v.pslverr = err;
    end

    if (push) begin
      v.mem[r.wr_ptr] = i_apbi.pwdata;
      v.wr_ptr        = r.wr_ptr + PTR_ONE;
    end
    if (pop) v.rd_ptr = r.rd_ptr + PTR_ONE;
    case ({push, pop})
      2'b10:   v.count = r.count + CNT_ONE;
      2'b01:   v.count = r.count - CNT_ONE;
      default: v.count = r.count;
    endcase

    // flush overrides any pop in the same cycle
    if (flush) begin
      v.rd_ptr = '0;
      v.wr_ptr = '0;
      v.count  = '0;
    end

    v.irq = v.irq_en & (8'(v.count) <= v.thresh);
  end

  if (async_reset) begin : g_async_rst
    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) r <= R_RESET;
      else         r <= v;
    end
  end else begin : g_sync_rst
    always_ff @(posedge i_clk) begin
      if (!i_nrst) r <= R_RESET;
      else         r <= v;
    end
  end

  assign o_cfg.descrsize  = PNP_CFG_DEV_DESCR_BYTES;
  assign o_cfg.descrtype  = PNP_CFG_TYPE_SLAVE;
  assign o_cfg.addr_start = i_mapinfo.addr_start;
  assign o_cfg.addr_end   = i_mapinfo.addr_end;
  assign o_cfg.vid        = VENDOR_OPTIMITECH;
  assign o_cfg.did        = did;

  assign o_apbo.pready  = r.pready;
  assign o_apbo.prdata  = r.prdata;
  assign o_apbo.pslverr = r.pslverr;

  assign o_cmd_valid = cmd_valid_c;
  assign o_cmd_data  = r.mem[r.rd_ptr];
  assign o_irq       = r.irq;

endmodule

// File: tb/tb_accel_apb_cmdfifo.sv
// Directed bench for accel_apb_cmdfifo: register access, FIFO fill/drain, flush, IRQ, errors.
module tb_accel_apb_cmdfifo;
  import accel_apb_cmdfifo_pkg::*;

  localparam logic [31:0] BASE = 32'h0801_0000;

  logic           clk = 1'b0;
  logic           nrst;
  mapinfo_type    mapinfo;
  dev_config_type cfg;
  apb_in_type     apbi;
  apb_out_type    apbo;
  logic           cmd_valid;
  logic [31:0]    cmd_data;
  logic           cmd_ready;
  logic           irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  accel_apb_cmdfifo dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_mapinfo   (mapinfo),
    .o_cfg       (cfg),
    .i_apbi      (apbi),
    .o_apbo      (apbo),
    .o_cmd_valid (cmd_valid),
    .o_cmd_data  (cmd_data),
    .i_cmd_ready (cmd_ready),
    .o_irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One APB transfer; optional single-cycle consumer pop aligned with the execute edge
  task automatic apb(input logic wr, input logic [11:0] offs, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic pop_exec,
                     output logic [31:0] rdata, output logic err);
    int waits;
    @(posedge clk); #1;
    apbi.paddr   = BASE | 32'(offs);
    apbi.pwrite  = wr;
    apbi.pwdata  = wdata;
    apbi.pstrb   = strb;
    apbi.pselx   = 1'b1;
    apbi.penable = 1'b0;
    @(posedge clk); #1;
    apbi.penable = 1'b1;
    if (pop_exec) cmd_ready = 1'b1;
    waits = 0;
    while (!apbo.pready && waits < 8) begin
      waits++;
      @(posedge clk); #1;
      if (pop_exec) cmd_ready = 1'b0;
    end
    check("apb_wait_states", 32'(waits), 32'd1);
    rdata = apbo.prdata;
    err   = apbo.pslverr;
    @(posedge clk); #1;
    check("pready_one_cycle", {31'h0, apbo.pready}, 32'h0);
    apbi.pselx   = 1'b0;
    apbi.penable = 1'b0;
    apbi.pwrite  = 1'b0;
  endtask

  task automatic wr_reg(input logic [11:0] offs, input logic [31:0] wdata);
    apb(1'b1, offs, wdata, 4'hF, 1'b0, rd, er);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] offs, input logic [31:0] exp);
    apb(1'b0, offs, 32'h0, 4'h0, 1'b0, rd, er);
    check(tag, rd, exp);
  endtask

  task automatic push(input logic [31:0] wdata, input logic pop_exec, input logic exp_err);
    apb(1'b1, 12'h00C, wdata, 4'hF, pop_exec, rd, er);
    check("push_pslverr", {31'h0, er}, {31'h0, exp_err});
  endtask

  initial begin
    int n;
    nrst      = 1'b0;
    apbi      = '0;
    cmd_ready = 1'b0;
    mapinfo.addr_start = 48'h0000_0801_0000;
    mapinfo.addr_end   = 48'h0000_0801_1000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready",    {31'h0, apbo.pready},  32'h0);
    check("rst_prdata",    apbo.prdata,           32'h0);
    check("rst_pslverr",   {31'h0, apbo.pslverr}, 32'h0);
    check("rst_cmd_valid", {31'h0, cmd_valid},    32'h0);
    check("rst_cmd_data",  cmd_data,              32'h0);
    check("rst_irq",       {31'h0, irq},          32'h0);
    nrst = 1'b1;

    check("cfg_vid",   {16'h0, cfg.vid},  32'h0000_00F1);
    check("cfg_did",   {16'h0, cfg.did},  32'h0);
    check("cfg_start", cfg.addr_start[31:0], 32'h0801_0000);
    check("cfg_end",   cfg.addr_end[31:0],   32'h0801_1000);

    rd_chk("id_read",    12'h000, 32'hACCE_C0F0);
    rd_chk("status_rst", 12'h004, 32'h0000_0001);

    // fill with consumer disabled, then overflow
    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i), 1'b0, 1'b0);
    rd_chk("status_full", 12'h004, 32'h0000_1002);
    push(32'h1FF, 1'b0, 1'b1);
    rd_chk("status_ovf", 12'h004, 32'h0000_1006);
    wr_reg(12'h004, 32'h4);
    rd_chk("status_ovf_clr", 12'h004, 32'h0000_1002);

    // drain with alternating backpressure
    wr_reg(12'h008, 32'h1);
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 16; cyc++) begin
      cmd_ready = (cyc % 2 == 0);
      if (cmd_valid && cmd_ready) begin
        check("drain_data", cmd_data, 32'h100 + 32'(n));
        n++;
      end
      @(posedge clk); #1;
    end
    cmd_ready = 1'b0;
    check("drain_count", 32'(n), 32'd16);
    check("drain_valid", {31'h0, cmd_valid}, 32'h0);
    rd_chk("status_drained", 12'h004, 32'h0000_0001);

    // concurrent push and pop
    for (int i = 0; i < 5; i++) push(32'h200 + 32'(i), 1'b0, 1'b0);
    check("head_before", cmd_data, 32'h200);
    push(32'h205, 1'b1, 1'b0);
    rd_chk("status_cnt5", 12'h004, 32'h0000_0500);
    check("head_after", cmd_data, 32'h201);
    for (int i = 6; i < 17; i++) push(32'h200 + 32'(i), 1'b0, 1'b0);
    rd_chk("status_cnt16", 12'h004, 32'h0000_1002);
    push(32'h211, 1'b1, 1'b1);
    rd_chk("status_full_pop", 12'h004, 32'h0000_0F04);
    check("head_full_pop", cmd_data, 32'h202);
    wr_reg(12'h004, 32'h4);
    rd_chk("status_cnt15", 12'h004, 32'h0000_0F00);

    // flush and low-water interrupt
    wr_reg(12'h008, 32'h2);
    rd_chk("status_flush1", 12'h004, 32'h0000_0001);
    wr_reg(12'h010, 32'h2);
    rd_chk("thresh_read", 12'h010, 32'h2);
    wr_reg(12'h008, 32'h4);
    check("irq_low", {31'h0, irq}, 32'h1);
    for (int i = 0; i < 8; i++) push(32'h300 + 32'(i), 1'b0, 1'b0);
    check("irq_above", {31'h0, irq}, 32'h0);
    rd_chk("status_cnt8", 12'h004, 32'h0000_0800);
    wr_reg(12'h008, 32'h5);
    check("valid_before_flush", {31'h0, cmd_valid}, 32'h1);
    apb(1'b1, 12'h008, 32'h7, 4'hF, 1'b1, rd, er);
    check("valid_after_flush", {31'h0, cmd_valid}, 32'h0);
    check("irq_after_flush",   {31'h0, irq},       32'h1);
    rd_chk("status_flush2", 12'h004, 32'h0000_0001);
    rd_chk("ctrl_read",     12'h008, 32'h0000_0005);

    // error paths
    apb(1'b1, 12'h00C, 32'hDEAD_BEEF, 4'h3, 1'b0, rd, er);
    check("strb_pslverr", {31'h0, er}, 32'h1);
    rd_chk("status_strb", 12'h004, 32'h0000_0009);
    apb(1'b0, 12'h040, 32'h0, 4'h0, 1'b0, rd, er);
    check("bad_off_pslverr", {31'h0, er}, 32'h1);
    check("bad_off_prdata",  rd,          32'h0);
    apb(1'b1, 12'h040, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er);
    check("bad_off_wr_pslverr", {31'h0, er}, 32'h1);
    rd_chk("status_no_side", 12'h004, 32'h0000_0009);
    rd_chk("push_read_zero", 12'h00C, 32'h0);
    wr_reg(12'h004, 32'h8);
    rd_chk("status_strb_clr", 12'h004, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
